// File: rtl/mem_loader.sv
// mem_loader: host-command bridge that writes and reads the CPU instruction
// and data memories through their external ports, and runs the CPU for a
// given number of cycles. Each command produces exactly one response.
module mem_loader #(
  parameter int ADDR_W    = 64,
  parameter int RUN_CNT_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  // host command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_data,
  // host response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              rsp_err,
  // instruction memory external port
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  input  logic [31:0]       rdata_ext,
  // data memory external port
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [63:0]       wdata_ext_2,
  input  logic [63:0]       rdata_ext_2,
  // CPU run enable
  output logic              enable
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ_REQ, S_READ_WAIT, S_RUN, S_RESP
  } state_t;

  // Opcode bit 0 selects the data memory, bit 1 selects a read.
  localparam logic [2:0] OP_WR_IMEM = 3'b000;
  localparam logic [2:0] OP_WR_DMEM = 3'b001;
  localparam logic [2:0] OP_RD_IMEM = 3'b010;
  localparam logic [2:0] OP_RD_DMEM = 3'b011;
  localparam logic [2:0] OP_RUN     = 3'b100;

  state_t                 state_q, state_d;
  logic [2:0]             op_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [63:0]            data_q;
  logic [RUN_CNT_W-1:0]   cnt_q;
  logic [63:0]            rsp_data_q;
  logic                   rsp_err_q;

  logic                   accept;
  logic                   cmd_legal;
  logic [RUN_CNT_W-1:0]   run_len;
  logic                   imem_act;
  logic                   dmem_act;

  // cmd_ready also looks at arst so it is low for the whole reset window.
  assign cmd_ready = (state_q == S_IDLE) && !arst;
  assign accept    = cmd_valid && cmd_ready;
  assign run_len   = cmd_data[RUN_CNT_W-1:0];

  // Decode legality of the incoming command (opcode and alignment).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    cmd_legal = 1'b0;
    case (cmd_op)
      OP_WR_IMEM, OP_RD_IMEM: cmd_legal = (cmd_addr[1:0] == 2'b00);
      OP_WR_DMEM, OP_RD_DMEM: cmd_legal = (cmd_addr[2:0] == 3'b000);
      OP_RUN:                 cmd_legal = 1'b1;
      default:                cmd_legal = 1'b0;
    endcase
  end

  // State register; async reset discards any in-flight command or response.
  always_ff @(posedge clk or posedge arst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and memory/run strobes, decoded from the current state.
  always_comb begin
    state_d   = state_q;
    wen_ext   = 1'b0;
    ren_ext   = 1'b0;
    wen_ext_2 = 1'b0;
    ren_ext_2 = 1'b0;
    enable    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!cmd_legal)                 state_d = S_RESP;
          else if (cmd_op == OP_RUN)      state_d = (run_len == '0) ? S_RESP : S_RUN;
          else if (cmd_op[1])             state_d = S_READ_REQ;
          else                            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wen_ext   = !op_q[0];
        wen_ext_2 = op_q[0];
        state_d   = S_RESP;
      end
      S_READ_REQ: begin
        ren_ext   = !op_q[0];
        ren_ext_2 = op_q[0];
        state_d   = S_READ_WAIT;
      end
      S_READ_WAIT: state_d = S_RESP;
      S_RUN: begin
        enable = 1'b1;
        if (cnt_q == RUN_CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the command at acceptance, count the run down, capture read data.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= cmd_op;
        addr_q     <= cmd_addr;
        data_q     <= cmd_data;
        cnt_q      <= run_len;
        rsp_err_q  <= !cmd_legal;
        rsp_data_q <= (cmd_legal && cmd_op == OP_RUN) ? 64'(run_len) : 64'd0;
      end
      // Count stops leaving RUN at 1, so it never wraps, even for all-ones N.
      if (state_q == S_RUN) cnt_q <= cnt_q - RUN_CNT_W'(1);
      if (state_q == S_READ_WAIT)
        rsp_data_q <= op_q[0] ? rdata_ext_2 : 64'(rdata_ext);
    end
  end

  // Address and write data are forced to zero outside their port's strobes.
  assign imem_act    = wen_ext   || ren_ext;
  assign dmem_act    = wen_ext_2 || ren_ext_2;
  assign addr_ext    = imem_act  ? addr_q       : '0;
  assign wdata_ext   = wen_ext   ? data_q[31:0] : '0;
  assign addr_ext_2  = dmem_act  ? addr_q       : '0;
  assign wdata_ext_2 = wen_ext_2 ? data_q       : '0;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : 64'd0;
  assign rsp_err   = rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: behavioural instruction/data memories,
// a response scoreboard, a vector table and hand-written corner sequences.
module tb_mem_loader;

  localparam int ADDR_W    = 64;
  localparam int RUN_CNT_W = 32;

  localparam logic [2:0] WR_IMEM = 3'b000;
  localparam logic [2:0] WR_DMEM = 3'b001;
  localparam logic [2:0] RD_IMEM = 3'b010;
  localparam logic [2:0] RD_DMEM = 3'b011;
  localparam logic [2:0] RUN     = 3'b100;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [63:0]       cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [63:0]       rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] addr_ext, addr_ext_2;
  logic              wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0]       wdata_ext;
  logic [31:0]       rdata_ext = '0;
  logic [63:0]       wdata_ext_2;
  logic [63:0]       rdata_ext_2 = '0;
  logic              enable;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(ADDR_W), .RUN_CNT_W(RUN_CNT_W)) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable)
  );

  // Synchronous-read memories: data appears the cycle after the ren cycle.
  logic [31:0] imem [0:255];
  logic [63:0] dmem [0:255];
  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[9:2]]   <= wdata_ext;
    if (ren_ext)   rdata_ext             <= imem[addr_ext[9:2]];
    if (wen_ext_2) dmem[addr_ext_2[10:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2           <= dmem[addr_ext_2[10:3]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];
  int   n_rsp = 0;

  // Scoreboard: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (!arst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Strobe counters, last write address/data, and protocol rule violations.
  int cnt_wen = 0, cnt_ren = 0, cnt_wen2 = 0, cnt_ren2 = 0, cnt_en = 0;
  int proto_bad = 0;
  logic [63:0] last_addr = '0, last_wdata = '0;
  always @(negedge clk) begin
    cnt_wen  += int'(wen_ext);
    cnt_ren  += int'(ren_ext);
    cnt_wen2 += int'(wen_ext_2);
    cnt_ren2 += int'(ren_ext_2);
    cnt_en   += int'(enable);
    if (wen_ext)   begin last_addr = addr_ext;   last_wdata = 64'(wdata_ext); end
    if (wen_ext_2) begin last_addr = addr_ext_2; last_wdata = wdata_ext_2;     end
    if ((int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) + int'(ren_ext_2)) > 1) proto_bad++;
    if (enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) proto_bad++;
    if (!(wen_ext || ren_ext) && addr_ext != '0) proto_bad++;
    if (!wen_ext && wdata_ext != '0) proto_bad++;
    if (!(wen_ext_2 || ren_ext_2) && addr_ext_2 != '0) proto_bad++;
    if (!wen_ext_2 && wdata_ext_2 != '0) proto_bad++;
  end

  // Present a command until accepted, then scramble the cmd_* inputs.
  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_addr  = {$urandom, $urandom};
    cmd_data  = {$urandom, $urandom};
  endtask

  // Cycles (edges after acceptance) until cmd_ready returns, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!cmd_ready && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
    int          lat;
    int          n_wen, n_ren, n_wen2, n_ren2, n_en;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    int   lat;
    int   w0, r0, w20, r20, e0, rsp0;
    logic stable;
    logic [63:0] cap;

    // Vector table: lat counts edges after acceptance until cmd_ready,
    // so write = 2 (3 cycles incl. acceptance), read = 3, error = 1, RUN N = N+1.
    vecs[0]  = '{WR_IMEM, 64'h8,  64'h0000_0000_0050_0093, 64'h0, 1'b0, 2, 1, 0, 0, 0, 0};
    vecs[1]  = '{WR_DMEM, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 2, 0, 0, 1, 0, 0};
    vecs[2]  = '{RD_DMEM, 64'h10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3, 0, 0, 0, 1, 0};
    vecs[3]  = '{RD_IMEM, 64'h8,  64'h0, 64'h0000_0000_0050_0093, 1'b0, 3, 0, 1, 0, 0, 0};
    vecs[4]  = '{RD_DMEM, 64'h4,  64'h0, 64'h0, 1'b1, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{3'b111,  64'h0,  64'h0, 64'h0, 1'b1, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{WR_IMEM, 64'h2,  64'h1234, 64'h0, 1'b1, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{RUN,     64'h0,  64'h0, 64'h0, 1'b0, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{RUN,     64'h0,  64'h5, 64'h5, 1'b0, 6, 0, 0, 0, 0, 5};
    vecs[9]  = '{WR_IMEM, 64'hC,  64'hFFFF_FFFF_8765_4321, 64'h0, 1'b0, 2, 1, 0, 0, 0, 0};
    vecs[10] = '{RD_IMEM, 64'hC,  64'h0, 64'h0000_0000_8765_4321, 1'b0, 3, 0, 1, 0, 0, 0};
    vecs[11] = '{WR_DMEM, 64'h1C, 64'h55, 64'h0, 1'b1, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{3'b101,  64'h0,  64'h7, 64'h0, 1'b1, 1, 0, 0, 0, 0, 0};
    vecs[13] = '{RUN,     64'h0,  64'hFFFF_FFFF_0000_0003, 64'h3, 1'b0, 4, 0, 0, 0, 0, 3};

    // Reset: everything low, cmd_ready low during reset and high right after.
    arst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_enable",    64'(enable),    64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    arst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Table-driven commands.
    for (int i = 0; i < NV; i++) begin
      w0 = cnt_wen; r0 = cnt_ren; w20 = cnt_wen2; r20 = cnt_ren2; e0 = cnt_en;
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_err});
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      wait_ready(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_rsp_drained", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("v%0d_wen", i),    64'(cnt_wen - w0),   64'(vecs[i].n_wen));
      check($sformatf("v%0d_ren", i),    64'(cnt_ren - r0),   64'(vecs[i].n_ren));
      check($sformatf("v%0d_wen2", i),   64'(cnt_wen2 - w20), 64'(vecs[i].n_wen2));
      check($sformatf("v%0d_ren2", i),   64'(cnt_ren2 - r20), 64'(vecs[i].n_ren2));
      check($sformatf("v%0d_enable", i), 64'(cnt_en - e0),    64'(vecs[i].n_en));
      if (vecs[i].n_wen == 1) begin
        check($sformatf("v%0d_waddr", i), last_addr, vecs[i].addr);
        check($sformatf("v%0d_wdata", i), last_wdata, {32'd0, vecs[i].data[31:0]});
      end else if (vecs[i].n_wen2 == 1) begin
        check($sformatf("v%0d_waddr", i), last_addr, vecs[i].addr);
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].data);
      end
    end

    // Response stall: held 10 cycles with a competing command pending.
    rsp_ready = 1'b0;
    exp_q.push_back('{64'hDEAD_BEEF_CAFE_F00D, 1'b0});
    send(RD_DMEM, 64'h10, 64'h0);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    cap = rsp_data;
    cmd_valid = 1'b1;
    cmd_op    = RUN;
    cmd_addr  = '0;
    cmd_data  = 64'd3;
    e0 = cnt_en;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== cap || cmd_ready) stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    check("stall_no_accept", 64'(cnt_en - e0), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_ready_next_cycle", 64'(cmd_ready), 64'd1);
    check("stall_rsp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in cycle 3 of RUN N=100: enable drops at once, no response follows.
    send(RUN, 64'h0, 64'd100);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("run_before_rst", 64'(enable), 64'd1);
    arst = 1'b1;
    #1;
    check("rst_mid_run_enable", 64'(enable), 64'd0);
    check("rst_mid_run_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    check("rst_mid_run_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp0 = n_rsp;
    e0   = cnt_en;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_response", 64'(n_rsp - rsp0), 64'd0);
    check("rst_no_enable", 64'(cnt_en - e0), 64'd0);

    // Normal operation resumes after reset.
    exp_q.push_back('{64'hDEAD_BEEF_CAFE_F00D, 1'b0});
    send(RD_DMEM, 64'h10, 64'h0);
    wait_ready(lat);
    check("post_rst_read_latency", 64'(lat), 64'd3);
    check("post_rst_rsp_drained", 64'(exp_q.size()), 64'd0);

    check("protocol_rules", 64'(proto_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_W, default 64, width of the byte addresses driven on both external memory ports.
REQ-002 Parameter RUN_CNT_W, default 32, width of the RUN cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 arst  input  1  reset, asynchronous assert, active-high.
REQ-005 cmd_valid  input  1; cmd_ready  output  1 -- host command handshake; transfer when both are high on a rising edge.
REQ-006 cmd_op  input  3  command: 000 WR_IMEM, 001 WR_DMEM, 010 RD_IMEM, 011 RD_DMEM, 100 RUN, others reserved.
REQ-007 cmd_addr  input  ADDR_W  byte address; cmd_data  input  64  write data, or run length in [RUN_CNT_W-1:0] for RUN.
REQ-008 rsp_valid  output  1; rsp_ready  input  1 -- response handshake; rsp_data  output  64; rsp_err  output  1.
REQ-009 addr_ext  output  ADDR_W; wen_ext  output  1; ren_ext  output  1; wdata_ext  output  32; rdata_ext  input  32 -- instruction memory external port.
REQ-010 addr_ext_2  output  ADDR_W; wen_ext_2  output  1; ren_ext_2  output  1; wdata_ext_2  output  64; rdata_ext_2  input  64 -- data memory external port.
REQ-011 enable  output  1  CPU run enable.

Function
REQ-012 The FSM SHALL have states IDLE, WRITE, READ_REQ, READ_WAIT, RUN and RESP.
REQ-013 cmd_ready SHALL be high only in IDLE; a command is accepted only in IDLE.
REQ-014 All command fields SHALL be registered at acceptance; later changes on cmd_* SHALL have no effect.
REQ-015 Alignment: WR_IMEM/RD_IMEM SHALL need cmd_addr[1:0]=0 and WR_DMEM/RD_DMEM SHALL need cmd_addr[2:0]=0.
REQ-016 A misaligned or reserved command SHALL go directly to RESP with rsp_err=1 and rsp_data=0, with no memory strobe.
REQ-017 WRITE SHALL last one cycle: the selected wen (wen_ext or wen_ext_2) is high for exactly that cycle, with the address and data (wdata_ext = data[31:0]) valid in it; then RESP with rsp_data=0.
REQ-018 READ_REQ SHALL last one cycle with the selected ren high and the address valid.
REQ-019 READ_WAIT SHALL capture the read data one cycle after the ren cycle: rdata_ext zero-extended to 64 bits, or rdata_ext_2; then RESP.
REQ-020 RUN with count N>0 SHALL hold enable high for exactly N consecutive cycles, starting the cycle after acceptance.
REQ-021 At the end of RUN the FSM SHALL go to RESP with rsp_data=N.
REQ-022 RUN with N=0 SHALL never raise enable and SHALL go directly to RESP with rsp_data=0.
REQ-023 The run counter SHALL count down from N with no wrap-around; N = 2^RUN_CNT_W-1 SHALL be legal.
REQ-024 In RESP, rsp_valid, rsp_data and rsp_err SHALL stay stable until rsp_ready is high; the FSM then returns to IDLE the next cycle.
REQ-025 rsp_ready held high SHALL give one response per command with no duplicates.
REQ-026 At most one of wen_ext, ren_ext, wen_ext_2, ren_ext_2 SHALL be high in any cycle.
REQ-027 All four strobes SHALL be low whenever enable is high.
REQ-028 addr_ext, addr_ext_2, wdata_ext and wdata_ext_2 SHALL be 0 whenever their port's strobes are low.
REQ-029 Throughput: writes SHALL take 3 cycles from acceptance to the next cmd_ready at rsp_ready=1, and reads SHALL take 4.

Reset
REQ-030 While arst is high, the FSM SHALL be in IDLE and every output SHALL be 0 except cmd_ready.
REQ-031 cmd_ready SHALL be 0 while arst is high and 1 in the first cycle after release.
REQ-032 Reset asserted mid-RUN or mid-access SHALL drop enable and all strobes in the same cycle, asynchronously.
REQ-033 After reset release, the pending response SHALL be discarded.

Verification
REQ-034 WR_IMEM addr=0x8, data=0x00500093 -> wen_ext high for one cycle with addr_ext=0x8 and wdata_ext=0x00500093; rsp_err=0.
REQ-035 WR_DMEM 0x10 = 0xDEADBEEF_CAFEF00D, then RD_DMEM 0x10 -> rsp_data=0xDEADBEEF_CAFEF00D; ren_ext_2 high for exactly one cycle.
REQ-036 RD_DMEM addr=0x4 -> rsp_err=1, no strobe; opcode 111 -> rsp_err=1.
REQ-037 RUN N=5 -> enable high for exactly 5 cycles, cmd_ready low throughout, rsp_data=5; RUN N=0 -> enable never high, rsp_data=0.
REQ-038 Hold rsp_ready low for 10 cycles after a read -> rsp_valid/rsp_data stable, no new command accepted; raise rsp_ready -> cmd_ready the next cycle.
REQ-039 Assert arst in cycle 3 of RUN N=100 -> enable 0 immediately; after release, cmd_ready=1 and no response is issued.
